// File: rtl/fifo_uart_tx_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : fifo_uart_tx_pkg
//  Description : Shared types and default constants for the FIFO-fed UART
//                transmitter: FSM state encoding, frame defaults and a helper
//                that sizes counters.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_uart_tx_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   localparam int C_DBIT       = 8;
   localparam int C_SB_TICK    = 16;
   localparam int C_OVERSAMPLE = 16;

   // Width needed to count 0..n-1, never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_uart_tx_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : fifo_uart_tx_if
//  Description : Read-side handshake between an upstream FIFO and the UART
//                transmitter.
//  Signals     : empty  - FIFO empty flag (FIFO -> transmitter)
//                r_data - FIFO head word, valid while empty=0
//                rd     - one-cycle pop strobe (transmitter -> FIFO)
//  Modports    : master - FIFO side, slave - transmitter side
//  Revision    : 1.0 - initial release
// ============================================================================
interface fifo_uart_tx_if
   import fifo_uart_tx_pkg::*;
#(
   parameter int DBIT = C_DBIT
);
   logic            empty;
   logic [DBIT-1:0] r_data;
   logic            rd;

   modport master (output empty, output r_data, input rd);
   modport slave  (input empty, input r_data, output rd);
endinterface
`default_nettype wire

// File: rtl/fifo_uart_tx_baud_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : baud_gen
//  Description : Oversample tick generator. tick is high for one clock when
//                the counter equals the active divisor, then the counter wraps.
//  Ports       : clk   - system clock
//                reset - asynchronous active-low reset
//                clr   - synchronous restart of the count (frame start)
//                dvsr  - divisor; a tick every dvsr+1 clocks
//                tick  - oversample tick
//  Revision    : 1.0 - initial release
// ============================================================================
module baud_gen #(
   parameter int DVSR_WIDTH = 11
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clr,
   input  logic [DVSR_WIDTH-1:0] dvsr,
   output logic                  tick
);

   logic [DVSR_WIDTH-1:0] cnt_q;
   // Divisor in use; resampled only at a wrap or restart so a change on the
   // dvsr input never truncates or stretches a tick period already running.
   logic [DVSR_WIDTH-1:0] lim_q;

   assign tick = (cnt_q == lim_q);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
         lim_q <= '0;
      end else if (clr || tick) begin
         cnt_q <= '0;
         lim_q <= dvsr;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/fifo_uart_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : fifo_uart_tx
//  Description : UART transmitter that pulls words from an upstream FIFO and
//                sends start, DBIT data bits (LSB first) and stop bits at a
//                16x oversampled baud rate.
//  Ports       : clk     - system clock
//                reset   - asynchronous active-low reset
//                dvsr    - baud divisor (oversample tick every dvsr+1 clocks)
//                fifo    - FIFO read handshake (empty, r_data, rd)
//                tx      - registered serial output, idle high
//                tx_busy - high whenever a frame is in progress
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_uart_tx
   import fifo_uart_tx_pkg::*;
#(
   parameter int DBIT       = C_DBIT,
   parameter int SB_TICK    = C_SB_TICK,
   parameter int DVSR_WIDTH = 11
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DVSR_WIDTH-1:0] dvsr,
   fifo_uart_tx_if.slave         fifo,
   output logic                  tx,
   output logic                  tx_busy
);

   localparam int S_MAX = (SB_TICK > C_OVERSAMPLE) ? SB_TICK : C_OVERSAMPLE;
   localparam int S_W   = cnt_width(S_MAX);
   localparam int N_W   = cnt_width(DBIT);

   localparam logic [S_W-1:0] S_LAST  = S_W'(C_OVERSAMPLE - 1);
   localparam logic [S_W-1:0] SB_LAST = S_W'(SB_TICK - 1);
   localparam logic [N_W-1:0] N_LAST  = N_W'(DBIT - 1);

   state_t          state_q, state_d;
   logic [S_W-1:0]  s_q, s_d;     // oversample ticks within current bit
   logic [N_W-1:0]  n_q, n_d;     // data bit index
   logic [DBIT-1:0] b_q, b_d;     // shift register, LSB is next data bit
   logic            tx_q, tx_d;
   logic            pop;
   logic            tick;
   logic [DBIT-1:0] b_shift;

   assign b_shift = b_q >> 1;

   baud_gen #(
      .DVSR_WIDTH (DVSR_WIDTH)
   ) u_baud_gen (
      .clk   (clk),
      .reset (reset),
      .clr   (pop),
      .dvsr  (dvsr),
      .tick  (tick)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         s_q     <= '0;
         n_q     <= '0;
         b_q     <= '0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         n_q     <= n_d;
         b_q     <= b_d;
         tx_q    <= tx_d;
      end
   end

   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      n_d     = n_q;
      b_d     = b_q;
      tx_d    = tx_q;
      pop     = 1'b0;
      case (state_q)
         IDLE: begin
            tx_d = 1'b1;
            if (!fifo.empty) begin
               // Pop, capture the head word and drop the line for the start
               // bit on the same edge.
               pop     = 1'b1;
               b_d     = fifo.r_data;
               tx_d    = 1'b0;
               s_d     = '0;
               n_d     = '0;
               state_d = START;
            end
         end
         START: begin
            if (tick) begin
               if (s_q == S_LAST) begin
                  s_d     = '0;
                  n_d     = '0;
                  tx_d    = b_q[0];
                  state_d = DATA;
               end else begin
                  s_d = s_q + 1'b1;
               end
            end
         end
         DATA: begin
            if (tick) begin
               if (s_q == S_LAST) begin
                  s_d = '0;
                  b_d = b_shift;
                  if (n_q == N_LAST) begin
                     n_d     = '0;
                     tx_d    = 1'b1;
                     state_d = STOP;
                  end else begin
                     n_d  = n_q + 1'b1;
                     tx_d = b_shift[0];
                  end
               end else begin
                  s_d = s_q + 1'b1;
               end
            end
         end
         STOP: begin
            if (tick) begin
               if (s_q == SB_LAST) begin
                  s_d     = '0;
                  state_d = IDLE;
               end else begin
                  s_d = s_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // The pop decision is combinational from IDLE, so it is masked by reset to
   // keep rd low for as long as reset is held, even with data waiting.
   assign fifo.rd = pop & reset;
   assign tx      = tx_q;
   assign tx_busy = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_uart_tx
//  Description : Testbench for fifo_uart_tx. A queue models the upstream
//                FIFO; each word issued pushes its expected serial pattern,
//                divisor and pop cycle to a scoreboard, and a monitor checks
//                every frame the DUT starts plus the idle and reset outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_uart_tx;

   typedef struct {
      logic [9:0] bits;   // serial order: bit 0 = start bit, bit 9 = stop bit
      int         dvsr;
      int         at;     // cycle count at which rd must be seen
   } exp_t;

   logic        clk   = 1'b0;
   logic        reset = 1'b1;
   logic [10:0] dvsr  = '0;
   logic        tx;
   logic        tx_busy;

   fifo_uart_tx_if #(.DBIT(8)) ifc ();

   fifo_uart_tx #(
      .DBIT       (8),
      .SB_TICK    (16),
      .DVSR_WIDTH (11)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .dvsr    (dvsr),
      .fifo    (ifc),
      .tx      (tx),
      .tx_busy (tx_busy)
   );

   int         checks = 0;
   int         errors = 0;
   int         cyc    = 0;
   logic       rd_seen = 1'b0;
   logic [7:0] fq[$];
   exp_t       exp_q[$];

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, req, $time);
      end
   endtask

   task automatic refresh();
      ifc.empty  = (fq.size() == 0);
      ifc.r_data = (fq.size() != 0) ? fq[0] : 8'h00;
   endtask

   task automatic push(input logic [7:0] d);
      fq.push_back(d);
      refresh();
   endtask

   task automatic expect_frame(input logic [9:0] bits, input int dv, input int at);
      exp_t e;
      e.bits = bits;
      e.dvsr = dv;
      e.at   = at;
      exp_q.push_back(e);
   endtask

   // FIFO model: a pop seen during a cycle removes the head after the edge.
   always @(negedge clk) rd_seen = ifc.rd;

   always @(posedge clk) begin
      cyc = cyc + 1;
      if (rd_seen) begin
         #1;
         void'(fq.pop_front());
         rd_seen = 1'b0;
         refresh();
      end
   end

   // Checks one frame starting at the negedge where rd was seen. pend=1 means
   // the current negedge still needs handling by the caller.
   task automatic check_frame(output logic pend);
      exp_t e;
      int   bl;
      int   bad;
      pend = 1'b0;
      check("rd_expected", (exp_q.size() != 0), 1);
      if (exp_q.size() == 0) return;
      e = exp_q.pop_front();
      check("rd_cycle", cyc, e.at);
      bl = 16 * (e.dvsr + 1);
      for (int b = 0; b < 10; b++) begin
         bad = 0;
         for (int c = 0; c < bl; c++) begin
            @(negedge clk);
            if (!reset) begin
               pend = 1'b1;
               return;
            end
            if (tx !== e.bits[b] || tx_busy !== 1'b1 || ifc.rd !== 1'b0) bad++;
         end
         check($sformatf("frame_bit%0d_bad_clocks", b), bad, 0);
      end
      @(negedge clk);
      if (!reset) begin
         pend = 1'b1;
         return;
      end
      check("frame_end_tx_busy", tx_busy, 0);
      check("frame_gap_tx", tx, 1);
      pend = ifc.rd;
   endtask

   initial begin : monitor
      logic pend;
      pend = 1'b0;
      forever begin
         if (!pend) @(negedge clk);
         pend = 1'b0;
         if (!reset)
            check("reset_tx_rd_busy", {tx, ifc.rd, tx_busy}, 3'b100);
         else if (ifc.rd)
            check_frame(pend);
         else
            check("idle_tx_busy", {tx, tx_busy}, 2'b10);
      end
   end

   initial begin : stimulus
      ifc.empty  = 1'b1;
      ifc.r_data = 8'h00;
      #1 reset = 1'b0;

      // Reset held with data waiting, then a single A5 frame at dvsr=0.
      @(posedge clk); #1;
      push(8'hA5);
      repeat (4) @(posedge clk);
      #1 reset = 1'b1;
      expect_frame(10'h34A, 0, cyc);
      repeat (170) @(posedge clk);
      #1;

      // Back-to-back 00, FF at dvsr=1: second pop 321 clocks after the first.
      dvsr = 11'd1;
      push(8'h00);
      push(8'hFF);
      expect_frame(10'h200, 1, cyc);
      expect_frame(10'h3FE, 1, cyc + 321);
      repeat (660) @(posedge clk);
      #1;

      // dvsr=3: 64-clock bits, 640-clock frame.
      dvsr = 11'd3;
      push(8'h01);
      expect_frame(10'h202, 3, cyc);
      repeat (660) @(posedge clk);
      #1;

      // Reset in the middle of data bit 3, new word pushed while in reset.
      dvsr = 11'd0;
      push(8'h3C);
      expect_frame(10'h278, 0, cyc);
      repeat (71) @(posedge clk);
      #3 reset = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      push(8'hC3);
      repeat (5) @(posedge clk);
      #1 reset = 1'b1;
      expect_frame(10'h386, 0, cyc);
      repeat (170) @(posedge clk);
      #1;

      // Empty FIFO for 1000 clocks: line stays idle, no pops.
      repeat (1000) @(posedge clk);
      #1;

      check("scoreboard_drained", exp_q.size(), 0);
      check("fifo_drained", fq.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 SHALL have parameter DBIT, default 8, data bits per frame.
REQ-002 SHALL have parameter SB_TICK, default 16, stop-bit length in oversample ticks (16 = 1 stop bit).
REQ-003 SHALL have parameter DVSR_WIDTH, default 11, width of the baud divisor input.
REQ-004 SHALL have port clk  input  1  single system clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset).
REQ-006 SHALL have port dvsr  input  DVSR_WIDTH  baud divisor; oversample tick every dvsr+1 clocks.
REQ-007 SHALL have port empty  input  1  upstream FIFO empty flag.
REQ-008 SHALL have port r_data  input  DBIT  FIFO head word, valid combinationally whenever empty=0.
REQ-009 SHALL have port rd  output  1  one-cycle pop strobe to the FIFO.
REQ-010 SHALL have port tx  output  1  serial line, idle high.
REQ-011 SHALL have port tx_busy  output  1  high in every state except IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-013 IDLE with empty=0: SHALL assert rd for exactly one cycle, latch r_data into the shift register on that edge, and enter START.
REQ-014 IDLE with empty=1: SHALL hold rd=0, tx=1; no pop attempted on an empty FIFO.
REQ-015 rd SHALL never be asserted outside IDLE, and never on two consecutive cycles.
REQ-016 The baud counter SHALL clear to 0 on the pop edge; tick is high for one cycle when counter==dvsr, then counter wraps to 0.
REQ-017 dvsr=0 SHALL yield a tick every clock; dvsr changes SHALL take effect at the next counter wrap.
REQ-018 START SHALL drive tx=0 for 16 ticks (16*(dvsr+1) clocks), tx low from the cycle after the pop.
REQ-019 DATA SHALL send DBIT bits LSB first, 16 ticks each, shifting right after each bit.
REQ-020 STOP SHALL drive tx=1 for SB_TICK ticks, then return to IDLE.
REQ-021 Frame length SHALL be exactly (16*(DBIT+1)+SB_TICK)*(dvsr+1) clocks from pop edge to IDLE re-entry (160*(dvsr+1) at defaults).
REQ-022 Back-to-back words: the next pop SHALL occur on the first IDLE cycle, giving a one-clock line-idle gap between frames.
REQ-023 tx SHALL be driven from a register (glitch-free), updated on state/bit boundaries only.
REQ-024 Tick counter (0..15) and bit counter (0..DBIT-1) SHALL clear on each state transition.
REQ-025 empty rising mid-frame SHALL not affect the frame in flight.

Reset
REQ-026 reset=0 SHALL asynchronously force state=IDLE, rd=0, tx=1, tx_busy=0, all counters and shift register to 0.
REQ-027 Reset mid-frame SHALL abort the frame with tx=1 immediately; the aborted word is not re-popped.
REQ-028 First pop after reset release SHALL be no earlier than the first rising edge with reset=1 and empty=0.

Structure
REQ-029 A shared package SHALL hold the state enum (IDLE, START, DATA, STOP) and default constants DBIT=8, SB_TICK=16, OVERSAMPLE=16.
REQ-030 The baud tick generator SHALL be a separate sub-module named baud_gen (inputs clk, reset, clr, dvsr; output tick).
REQ-031 All remaining logic SHALL be a single registered FSM plus next-state logic in fifo_uart_tx.

Verification
REQ-032 Reset: hold reset=0 with empty=0 -> rd=0, tx=1, tx_busy=0 throughout; release -> rd=1 on first active edge.
REQ-033 Single frame: dvsr=0, r_data=8'hA5, empty=0 for one cycle then 1 -> one rd pulse; tx = 0,1,0,1,0,0,1,0,1,1 each 16 clocks; tx_busy low after 160 clocks.
REQ-034 Back-to-back: FIFO holds 8'h00, 8'hFF, dvsr=1 -> exactly 2 rd pulses 321 clocks apart; bit patterns match; tx=1 for one clock between frames.
REQ-035 Divisor: dvsr=3, r_data=8'h01 -> start bit lasts 64 clocks, bit0 high for 64 clocks, frame 640 clocks.
REQ-036 Mid-frame reset: assert reset=0 during DATA bit 3 -> tx=1 same cycle, no further rd until reset released and empty=0.
REQ-037 Empty FIFO: empty=1 for 1000 clocks -> rd never asserted, tx constantly 1.
